// File: rtl/add_accum.sv
// Framed multi-operand adder: accumulates up to NARG operands per frame and
// presents sum, carry-out, signed overflow and operand count with a ready/valid handshake.
module add_accum #(
  parameter int LEN  = 16,
  parameter int NARG = 4,
  parameter int SAT  = 0,
  localparam int CW  = $clog2(NARG),
  localparam int NW  = $clog2(NARG + 1)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [LEN-1:0]  IN_DATA,
  input  logic            IN_LAST,
  input  logic [CW-1:0]   IC,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [LEN-1:0]  Y,
  output logic [CW-1:0]   OC,
  output logic            OVF,
  output logic [NW-1:0]   CNT
);

  localparam int UW = LEN + CW;
  localparam int SW = LEN + CW + 1;

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  state_t                 state_q;
  logic [UW-1:0]          u_q, u_d;
  logic signed [SW-1:0]   s_q, s_d;
  logic [NW-1:0]          cnt_q, cnt_d;
  logic [LEN-1:0]         y_q, y_d;
  logic [CW-1:0]          oc_q;
  logic                   ovf_q, ovf_d;
  logic [NW-1:0]          ncnt_q;

  logic                   first;
  logic                   close;
  logic [UW-1:0]          u_in, u_ic;
  logic signed [SW-1:0]   s_in, s_ic;

  // S fits the signed LEN-bit range iff its bits from LEN-1 upward are all equal.
  function automatic logic s_ovf(input logic [CW+1:0] top);
    return !((&top) || !(|top));
  endfunction

  function automatic logic [LEN-1:0] sat_y(input logic [LEN-1:0] wrap,
                                           input logic neg, input logic ovf);
    if ((SAT != 0) && ovf)
      return neg ? {1'b1, {(LEN-1){1'b0}}} : {1'b0, {(LEN-1){1'b1}}};
    return wrap;
  endfunction

  always_comb begin
    first = (cnt_q == '0);
    u_in  = {{CW{1'b0}}, IN_DATA};
    u_ic  = {{LEN{1'b0}}, IC};
    s_in  = {{(CW+1){IN_DATA[LEN-1]}}, IN_DATA};
    s_ic  = {{(LEN+1){1'b0}}, IC};
    u_d   = first ? (u_in + u_ic) : (u_q + u_in);
    s_d   = (first ? s_ic : s_q) + s_in;
    cnt_d = cnt_q + NW'(1);
    close = IN_LAST || (cnt_d == NW'(NARG));
    ovf_d = s_ovf(s_d[SW-1:LEN-1]);
    y_d   = sat_y(u_d[LEN-1:0], s_d[SW-1], ovf_d);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ACC;
      u_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      oc_q    <= '0;
      ovf_q   <= 1'b0;
      ncnt_q  <= '0;
    end else if (state_q == ACC) begin
      if (IN_VALID) begin
        u_q <= u_d;
        s_q <= s_d;
        if (close) begin
          state_q <= HOLD;
          cnt_q   <= '0;
          y_q     <= y_d;
          oc_q    <= u_d[UW-1:LEN];
          ovf_q   <= ovf_d;
          ncnt_q  <= cnt_d;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end else if (OUT_READY) begin
      state_q <= ACC;
    end
  end

  assign IN_READY  = (state_q == ACC);
  assign OUT_VALID = (state_q == HOLD);
  assign Y         = y_q;
  assign OC        = oc_q;
  assign OVF       = ovf_q;
  assign CNT       = ncnt_q;

endmodule

// File: tb/tb_add_accum.sv
// Directed bench for add_accum: wrapping and saturating instances share one stimulus.
module tb_add_accum;

  localparam int LEN  = 16;
  localparam int NARG = 4;
  localparam int CW   = 2;
  localparam int NW   = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_last, out_ready;
  logic [LEN-1:0]  in_data;
  logic [CW-1:0]   ic;
  logic            in_ready0, out_valid0, ovf0;
  logic            in_ready1, out_valid1, ovf1;
  logic [LEN-1:0]  y0, y1;
  logic [CW-1:0]   oc0, oc1;
  logic [NW-1:0]   cnt0, cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  add_accum #(.LEN(LEN), .NARG(NARG), .SAT(0)) dut0 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready0),
    .IN_DATA(in_data), .IN_LAST(in_last), .IC(ic), .OUT_VALID(out_valid0),
    .OUT_READY(out_ready), .Y(y0), .OC(oc0), .OVF(ovf0), .CNT(cnt0)
  );

  add_accum #(.LEN(LEN), .NARG(NARG), .SAT(1)) dut1 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready1),
    .IN_DATA(in_data), .IN_LAST(in_last), .IC(ic), .OUT_VALID(out_valid1),
    .OUT_READY(out_ready), .Y(y1), .OC(oc1), .OVF(ovf1), .CNT(cnt1)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [LEN-1:0] d, input logic last, input logic [CW-1:0] c);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    ic       = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [LEN-1:0] ey0, input logic [LEN-1:0] ey1,
                           input logic [CW-1:0] eoc, input logic eovf, input logic [NW-1:0] ecnt);
    check_val({tag, "_ovalid0"}, 64'(out_valid0), 64'(1'b1));
    check_val({tag, "_ovalid1"}, 64'(out_valid1), 64'(1'b1));
    check_val({tag, "_iready"},  64'(in_ready0),  64'(1'b0));
    check_val({tag, "_y_wrap"},  64'(y0),   64'(ey0));
    check_val({tag, "_y_sat"},   64'(y1),   64'(ey1));
    check_val({tag, "_oc0"},     64'(oc0),  64'(eoc));
    check_val({tag, "_oc1"},     64'(oc1),  64'(eoc));
    check_val({tag, "_ovf0"},    64'(ovf0), 64'(eovf));
    check_val({tag, "_ovf1"},    64'(ovf1), 64'(eovf));
    check_val({tag, "_cnt0"},    64'(cnt0), 64'(ecnt));
    check_val({tag, "_cnt1"},    64'(cnt1), 64'(ecnt));
  endtask

  task automatic check_idle(input string tag, input logic [LEN-1:0] ey0);
    check_val({tag, "_ovalid"}, 64'(out_valid0), 64'(1'b0));
    check_val({tag, "_iready"}, 64'(in_ready0),  64'(1'b1));
    check_val({tag, "_y"},      64'(y0),         64'(ey0));
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_data = '0; ic = '0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("rst", 16'h0000);
    check_val("rst_oc",  64'(oc0),  64'(0));
    check_val("rst_ovf", 64'(ovf0), 64'(0));
    check_val("rst_cnt", 64'(cnt0), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // positive overflow: 0x7FFF + 0x0001
    send(16'h7FFF, 1'b0, 2'd0);
    check_idle("f1_open", 16'h0000);
    send(16'h0001, 1'b1, 2'd0);
    check_out("f1", 16'h8000, 16'h7FFF, 2'd0, 1'b1, 3'd2);
    consume();
    check_idle("f1_done", 16'h8000);

    // negative overflow with carry-out: 0x8000 + 0x8000
    send(16'h8000, 1'b0, 2'd0);
    send(16'h8000, 1'b1, 2'd0);
    check_out("f2", 16'h0000, 16'h8000, 2'd1, 1'b1, 3'd2);
    consume();

    // auto-close on the NARG-th beat, carry-in 3
    for (int i = 0; i < 3; i++) send(16'hFFFF, 1'b0, 2'd3);
    check_idle("f3_open", 16'h0000);
    send(16'hFFFF, 1'b0, 2'd3);
    check_out("f3", 16'hFFFF, 16'hFFFF, 2'd3, 1'b0, 3'd4);

    // HOLD ignores input beats while the result is not consumed
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'h1111; in_last = 1'b1; ic = 2'd1;
      @(posedge clk);
      #1;
      check_out($sformatf("hold%0d", i), 16'hFFFF, 16'hFFFF, 2'd3, 1'b0, 3'd4);
    end
    in_valid = 1'b0; in_last = 1'b0;
    consume();
    check_idle("f3_done", 16'hFFFF);

    // mixed signs; IC on later beats must be ignored
    send(16'h0003, 1'b0, 2'd2);
    send(16'hFFFE, 1'b0, 2'd3);
    send(16'h0010, 1'b1, 2'd3);
    check_out("f4", 16'h0013, 16'h0013, 2'd1, 1'b0, 3'd3);
    consume();

    // single-beat frame with OUT_READY already high while in ACC
    out_ready = 1'b1;
    send(16'h1234, 1'b1, 2'd1);
    check_out("f5", 16'h1235, 16'h1235, 2'd0, 1'b0, 3'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_idle("f5_done", 16'h1235);

    // asynchronous reset mid-frame discards the partial frame
    send(16'h0100, 1'b0, 2'd0);
    send(16'h0200, 1'b0, 2'd0);
    #1 rst = 1'b1;
    #1;
    check_idle("arst", 16'h0000);
    check_val("arst_cnt", 64'(cnt0), 64'(0));
    #1 rst = 1'b0;
    send(16'h0005, 1'b1, 2'd0);
    check_out("f6", 16'h0005, 16'h0005, 2'd0, 1'b0, 3'd1);

    // asynchronous reset while HOLD discards the pending result
    #1 rst = 1'b1;
    #1;
    check_idle("hrst", 16'h0000);
    #1 rst = 1'b0;
    send(16'h0007, 1'b1, 2'd0);
    check_out("f7", 16'h0007, 16'h0007, 2'd0, 1'b0, 3'd1);
    consume();
    check_idle("f7_done", 16'h0007);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
